// File: rtl/seg7_time_capture.sv
`default_nettype none
// ============================================================================
// seg7_time_capture: filters 4-digit active-low 7-seg frames, decodes MM:SS
// and classifies each stable change. Option macro: SEGCAP_BLANK_EN. Rev 1.0
// ============================================================================
module seg7_time_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       y,
  input  logic [6:0]       y_1,
  input  logic [6:0]       y_2,
  input  logic [6:0]       y_3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_time,
  output logic [1:0]       out_kind,
  output logic [CNT_W-1:0] step_count,
  output logic             overrun
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
`ifdef SEGCAP_BLANK_EN
  localparam logic BLANK_OK = 1'b1;
`else
  localparam logic BLANK_OK = 1'b0;
`endif

  localparam logic [1:0] K_STEP  = 2'd0;
  localparam logic [1:0] K_CLEAR = 2'd1;
  localparam logic [1:0] K_JUMP  = 2'd2;
  localparam logic [1:0] K_ERR   = 2'd3;

  typedef enum logic [1:0] {SETTLE = 2'd0, ACCEPT = 2'd1, HOLD = 2'd2} state_t;

  // Returns {valid, digit}; invalid patterns yield digit 4'hF.
  function automatic logic [4:0] dec7(input logic [6:0] s, input logic blank_ok);
    case (s)
      7'h40:   dec7 = 5'h10;
      7'h79:   dec7 = 5'h11;
      7'h24:   dec7 = 5'h12;
      7'h30:   dec7 = 5'h13;
      7'h19:   dec7 = 5'h14;
      7'h12:   dec7 = 5'h15;
      7'h02:   dec7 = 5'h16;
      7'h78:   dec7 = 5'h17;
      7'h00:   dec7 = 5'h18;
      7'h10:   dec7 = 5'h19;
      7'h7F:   dec7 = blank_ok ? 5'h10 : 5'h0F;
      default: dec7 = 5'h0F;
    endcase
  endfunction

  function automatic logic [15:0] inc_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) r[7:4] = t[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [27:0]      seg_q, seg_prev_q, last_q, frame_q;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [15:0]      time_q, prev_q;
  logic             prev_vld_q;
  logic [1:0]       kind_q;
  logic [CNT_W-1:0] step_q;
  logic             ovr_q;

  logic             accept, handshake, load;
  logic [27:0]      src;
  logic [4:0]       dd0, dd1, dd2, dd3;
  logic [15:0]      c_time;
  logic             c_err;
  logic [1:0]       c_kind;

  always_comb begin
    cnt_d = cnt_q;
    if (seg_q != seg_prev_q)               cnt_d = '0;
    else if (cnt_q != SW'(STABLE_CYCLES))  cnt_d = cnt_q + SW'(1);
  end

  assign accept    = (seg_q == seg_prev_q) && (cnt_q == SW'(STABLE_CYCLES - 2)) && (seg_q != last_q);
  assign handshake = (state_q == HOLD) && out_ready;
  // A back-to-back event bypasses ACCEPT so out_valid never drops between events.
  assign load      = (state_q == ACCEPT) || (handshake && accept);

  always_comb begin
    src    = (state_q == ACCEPT) ? frame_q : seg_q;
    dd0    = dec7(src[6:0],   1'b0);
    dd1    = dec7(src[13:7],  1'b0);
    dd2    = dec7(src[20:14], BLANK_OK);
    dd3    = dec7(src[27:21], BLANK_OK);
    c_time = {dd3[3:0], dd2[3:0], dd1[3:0], dd0[3:0]};
    c_err  = !(dd0[4] && dd1[4] && dd2[4] && dd3[4]) || (dd1[3:0] > 4'd5) || (dd3[3:0] > 4'd5);
    if (c_err)                                        c_kind = K_ERR;
    else if (c_time == 16'h0000)                      c_kind = K_CLEAR;
    else if (prev_vld_q && c_time == inc_time(prev_q)) c_kind = K_STEP;
    else                                              c_kind = K_JUMP;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLE:  if (accept) state_d = ACCEPT;
      ACCEPT:  state_d = HOLD;
      HOLD:    if (handshake && !accept) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= SETTLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q      <= '0;
      seg_prev_q <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      frame_q    <= '0;
      time_q     <= '0;
      kind_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      step_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      seg_q      <= {y_3, y_2, y_1, y};
      seg_prev_q <= seg_q;
      cnt_q      <= cnt_d;
      if (accept) begin
        last_q  <= seg_q;
        frame_q <= seg_q;
      end
      if (load) begin
        time_q <= c_time;
        kind_q <= c_kind;
        if (c_kind != K_ERR) begin
          prev_q     <= c_time;
          prev_vld_q <= 1'b1;
        end
        if (c_kind == K_STEP && !(&step_q)) step_q <= step_q + CNT_W'(1);
      end
      if (state_q == HOLD && accept && !out_ready) ovr_q <= 1'b1;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_time   = time_q;
  assign out_kind   = kind_q;
  assign step_count = step_q;
  assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_time_capture.sv
`default_nettype none
// ============================================================================
// tb_seg7_time_capture: table-driven frames with an event scoreboard, plus
// latency, glitch, overrun and mid-run reset sequences. Rev 1.0
// ============================================================================
module tb_seg7_time_capture;

  localparam int STABLE = 4;
  localparam logic [1:0] K_STEP = 2'd0, K_CLEAR = 2'd1, K_JUMP = 2'd2, K_ERR = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  y = 7'h7F, y_1 = 7'h7F, y_2 = 7'h7F, y_3 = 7'h7F;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] out_time;
  logic [1:0]  out_kind;
  logic [15:0] step_count;
  logic        overrun;

  seg7_time_capture #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .y(y), .y_1(y_1), .y_2(y_2), .y_3(y_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
    .out_kind(out_kind), .step_count(step_count), .overrun(overrun)
  );

  always #10 clock = ~clock;

  typedef struct { logic [27:0] seg; logic [1:0] kind; logic [15:0] tim; } vec_t;
  typedef struct packed { logic [1:0] kind; logic [15:0] tim; } ev_t;

  vec_t vecs[18];
  ev_t  sb[$];
  int   n_tests = 0, n_fail = 0, n_events = 0, exp_steps = 0;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: pat = 7'h40; 4'd1: pat = 7'h79; 4'd2: pat = 7'h24; 4'd3: pat = 7'h30;
      4'd4: pat = 7'h19; 4'd5: pat = 7'h12; 4'd6: pat = 7'h02; 4'd7: pat = 7'h78;
      4'd8: pat = 7'h00; 4'd9: pat = 7'h10; default: pat = 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] frame(input logic [15:0] t);
    return {pat(t[15:12]), pat(t[11:8]), pat(t[7:4]), pat(t[3:0])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [27:0] s);
    @(posedge clock); #1;
    {y_3, y_2, y_1, y} = s;
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] t);
    sb.push_back('{k, t});
    if (k == K_STEP) exp_steps++;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
    check(name, sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_event actual time=%h kind=%0d required none", out_time, out_kind);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("ev_time", out_time, e.tim);
        check("ev_kind", out_kind, e.kind);
        n_events++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] tmp;
    int n, ev0;

    vecs[0]  = '{frame(16'h0000), K_CLEAR, 16'h0000};
    vecs[1]  = '{frame(16'h0001), K_STEP,  16'h0001};
    vecs[2]  = '{frame(16'h0002), K_STEP,  16'h0002};
    vecs[3]  = '{frame(16'h0062), K_ERR,   16'h0062};
    vecs[4]  = '{frame(16'h0003), K_STEP,  16'h0003};
    vecs[5]  = '{frame(16'h0005), K_JUMP,  16'h0005};
    vecs[6]  = '{frame(16'h0300), K_JUMP,  16'h0300};
    vecs[7]  = '{frame(16'h5959), K_JUMP,  16'h5959};
    vecs[8]  = '{frame(16'h0000), K_CLEAR, 16'h0000};
    vecs[9]  = '{frame(16'h0009), K_JUMP,  16'h0009};
    vecs[10] = '{frame(16'h0010), K_STEP,  16'h0010};
    vecs[11] = '{frame(16'h0959), K_JUMP,  16'h0959};
    vecs[12] = '{frame(16'h1000), K_STEP,  16'h1000};
    tmp = frame(16'h1000); tmp[6:0] = 7'h7F;
    vecs[13] = '{tmp,               K_ERR,   16'h100F};
    vecs[14] = '{frame(16'h6000), K_ERR,   16'h6000};
    vecs[15] = '{frame(16'h1001), K_STEP,  16'h1001};
    tmp = {7'h7F, 7'h79, 7'h40, 7'h40};
`ifdef SEGCAP_BLANK_EN
    vecs[16] = '{tmp, K_JUMP, 16'h0100};
`else
    vecs[16] = '{tmp, K_ERR,  16'hF100};
`endif
    vecs[17] = '{frame(16'h0000), K_CLEAR, 16'h0000};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_time", out_time, 0);
    check("rst_kind", out_kind, 0);
    check("rst_steps", step_count, 0);
    check("rst_overrun", overrun, 0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].seg);
      expect_ev(vecs[i].kind, vecs[i].tim);
      repeat (12) @(posedge clock);
    end
    wait_empty("table_drain");
    check("table_steps", step_count, exp_steps);

    // Edge counted from the first sampling edge: STABLE+1 edges later valid rises.
    drive(frame(16'h0001));
    expect_ev(K_STEP, 16'h0001);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (out_valid) begin n = k; break; end
    end
    check("latency_edges", n, STABLE + 2);
    wait_empty("latency_drain");

    ev0 = n_events;
    repeat (5) @(posedge clock);
    #1 y = 7'h7F;
    @(posedge clock); #1 y = 7'h79;
    repeat (20) @(posedge clock);
    check("glitch_no_event", n_events, ev0);

    out_ready = 1'b0;
    drive(frame(16'h0002));
    expect_ev(K_STEP, 16'h0002);
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("hold_valid", out_valid, 1);
    check("hold_overrun_clear", overrun, 0);
    drive(frame(16'h3333));
    repeat (10) @(posedge clock);
    drive(frame(16'h4444));
    repeat (10) @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("hold_time_stable", out_time, 16'h0002);
      check("hold_kind_stable", out_kind, K_STEP);
    end
    check("overrun_set", overrun, 1);
    @(posedge clock); #1 out_ready = 1'b1;
    wait_empty("overrun_drain");
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("after_drop_idle", out_valid, 0);
    check("overrun_sticky", overrun, 1);
    check("steps_after_drop", step_count, exp_steps);

    out_ready = 1'b0;
    drive(frame(16'h1234));
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("pre_reset_valid", out_valid, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_time", out_time, 0);
    check("midrst_steps", step_count, 0);
    check("midrst_overrun", overrun, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    expect_ev(K_JUMP, 16'h1234);
    wait_empty("post_reset_drain");
    check("post_reset_steps", step_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
